i2c_master_mmio: RTL

I2C_MASTER_MMIO -- requirements
Module: i2c_master_mmio

---
 rtl/i2c_master_mmio.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_master_mmio.sv
// Memory-mapped single-byte I2C master.
// A GO write launches one transaction: optional START, eight data bits, an
// ACK slot, and optional STOP. Every bus phase is split into four quarters
// whose length is set by the DIV register. The bus pins are registered and
// change only on quarter boundaries.
module i2c_master_mmio #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter logic [15:0] DEFAULT_DIV = 16'd50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        memwrite,
  output logic [31:0] rdata,
  output logic        scl,
  output logic        sda_oe,
  input  logic        sda_in,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BIT,
    S_ACK,
    S_STOP
  } state_e;

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_TXDATA = 3'd1;
  localparam logic [2:0] OFF_RXDATA = 3'd2;
  localparam logic [2:0] OFF_STATUS = 3'd3;
  localparam logic [2:0] OFF_DIV    = 3'd4;

  // CTRL field positions
  localparam int C_START  = 0;
  localparam int C_STOP   = 1;
  localparam int C_READ   = 2;
  localparam int C_ACKVAL = 3;
  localparam int C_GO     = 4;

  // Architectural registers
  logic [3:0]  ctrl_q;
  logic [7:0]  txdata_q;
  logic [7:0]  rxdata_q;
  logic [15:0] div_q;
  logic        busy_q;
  logic        done_q;
  logic        ack_err_q;

  // Sequencer state
  state_e      state_q, state_d;
  logic [1:0]  quarter_q, quarter_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] qcnt_q;
  logic        scl_q;
  logic        sda_oe_q;

  // Decoded bus-side signals
  logic        hit;
  logic [2:0]  offset;
  logic        wr_ctrl;
  logic        wr_txdata;
  logic        wr_div;
  logic        go;
  logic [15:0] div_m1;
  logic        tick;
  logic        finish;

  // Address bits [1:0] and the upper store-data bits carry no information.
  logic unused_bits;
  assign unused_bits = ^{addr[1:0], wdata[31:16]};

  assign hit       = (addr[31:5] == BASE_ADDR[31:5]);
  assign offset    = addr[4:2];
  assign wr_ctrl   = memwrite && hit && (offset == OFF_CTRL);
  assign wr_txdata = memwrite && hit && (offset == OFF_TXDATA);
  assign wr_div    = memwrite && hit && (offset == OFF_DIV);
  assign go        = wr_ctrl && wdata[C_GO] && !busy_q;

  // DIV=0 is treated as DIV=1, so the terminal count is 0 for both.
  assign div_m1 = (div_q == 16'd0) ? 16'd0 : (div_q - 16'd1);
  assign tick   = busy_q && (qcnt_q == div_m1);

  // Last quarter of the final phase: ACK without STOP, or STOP itself.
  assign finish = tick && (quarter_q == 2'd3) &&
                  (((state_q == S_ACK) && !ctrl_q[C_STOP]) || (state_q == S_STOP));

  // Bus levels {scl, sda_oe} to present during quarter q of phase st.
  function automatic logic [1:0] bus_levels(
    input state_e     st,
    input logic [1:0] q,
    input logic [2:0] idx,
    input logic       rd,
    input logic       ackval,
    input logic [7:0] tx
  );
    logic sda;
    logic scl_hi;
    bus_levels = 2'b10;
    scl_hi     = (q == 2'd1) || (q == 2'd2);
    case (st)
      S_START: begin
        case (q)
          2'd0, 2'd1: bus_levels = 2'b10;
          2'd2:       bus_levels = 2'b11;
          default:    bus_levels = 2'b01;
        endcase
      end
      S_BIT: begin
        sda        = rd ? 1'b0 : ~tx[idx];
        bus_levels = {scl_hi, sda};
      end
      S_ACK: begin
        sda        = rd ? ~ackval : 1'b0;
        bus_levels = {scl_hi, sda};
      end
      S_STOP: begin
        case (q)
          2'd0:    bus_levels = 2'b01;
          2'd1:    bus_levels = 2'b11;
          default: bus_levels = 2'b10;
        endcase
      end
      default: bus_levels = 2'b10;
    endcase
  endfunction

  // Position (phase, quarter, bit index) the sequencer moves to on this edge.
  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    quarter_d = quarter_q;
    idx_d     = idx_q;
    if (go) begin
      state_d   = wdata[C_START] ? S_START : S_BIT;
      quarter_d = 2'd0;
      idx_d     = 3'd7;
    end else if (tick) begin
      if (quarter_q != 2'd3) begin
        quarter_d = quarter_q + 2'd1;
      end else begin
        quarter_d = 2'd0;
        case (state_q)
          S_START: begin
            state_d = S_BIT;
            idx_d   = 3'd7;
          end
          S_BIT: begin
            state_d = (idx_q == 3'd0) ? S_ACK : S_BIT;
            idx_d   = idx_q - 3'd1;
          end
          S_ACK:   state_d = ctrl_q[C_STOP] ? S_STOP : S_IDLE;
          S_STOP:  state_d = S_IDLE;
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  // Register file, quarter timer, sequencer and registered bus pins.
  // NOTE: state registers use non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q    <= 4'd0;
      txdata_q  <= 8'd0;
      rxdata_q  <= 8'd0;
      div_q     <= DEFAULT_DIV;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      state_q   <= S_IDLE;
      quarter_q <= 2'd0;
      idx_q     <= 3'd0;
      qcnt_q    <= 16'd0;
      scl_q     <= 1'b1;
      sda_oe_q  <= 1'b0;
    end else begin
      // Configuration is frozen for the whole transaction.
      if (!busy_q) begin
        if (wr_ctrl)   ctrl_q   <= wdata[3:0];
        if (wr_txdata) txdata_q <= wdata[7:0];
        if (wr_div)    div_q    <= wdata[15:0];
      end

      if (go) begin
        busy_q    <= 1'b1;
        done_q    <= 1'b0;
        ack_err_q <= 1'b0;
        qcnt_q    <= 16'd0;
        state_q   <= state_d;
        quarter_q <= quarter_d;
        idx_q     <= idx_d;
        // CTRL is being latched on this same edge, so use the store data.
        {scl_q, sda_oe_q} <= bus_levels(state_d, quarter_d, idx_d,
                                        wdata[C_READ], wdata[C_ACKVAL], txdata_q);
      end else if (busy_q) begin
        qcnt_q <= tick ? 16'd0 : (qcnt_q + 16'd1);
        if (tick) begin
          state_q   <= state_d;
          quarter_q <= quarter_d;
          idx_q     <= idx_d;
          if (finish) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            // After STOP the bus is idle; otherwise hold SCL low, SDA released.
            {scl_q, sda_oe_q} <= {(state_q == S_STOP), 1'b0};
          end else begin
            {scl_q, sda_oe_q} <= bus_levels(state_d, quarter_d, idx_d,
                                            ctrl_q[C_READ], ctrl_q[C_ACKVAL], txdata_q);
          end
          // Sample point is the start of quarter 2, mid SCL-high.
          if (quarter_q == 2'd1) begin
            if ((state_q == S_BIT) && ctrl_q[C_READ])  rxdata_q[idx_q] <= sda_in;
            if ((state_q == S_ACK) && !ctrl_q[C_READ]) ack_err_q       <= sda_in;
          end
        end
      end
    end
  end

  // Combinational read mux; misses and unused offsets return zero.
  always_comb begin
    rdata = 32'd0;
    if (hit) begin
      case (offset)
        OFF_CTRL:   rdata = {28'd0, ctrl_q};
        OFF_TXDATA: rdata = {24'd0, txdata_q};
        OFF_RXDATA: rdata = {24'd0, rxdata_q};
        OFF_STATUS: rdata = {29'd0, done_q, ack_err_q, busy_q};
        OFF_DIV:    rdata = {16'd0, div_q};
        default:    rdata = 32'd0;
      endcase
    end
  end

  assign scl    = scl_q;
  assign sda_oe = sda_oe_q;
  assign busy   = busy_q;

endmodule
